departure_interlock: RTL

- Sequencer for the departure direction of the spacecraft airlock. The crew member goes from the cabin out through the inner door, the chamber depressurizes, and the crew member leaves through the outer door.
- It is the reverse counterpart of the arrival interlock and sits beside it under the board top-level.
- Driven by debounced switch/key requests; drives door, pump and status outputs to the display and LED logic.

---
 rtl/departure_interlock.sv | 122 ++++++++++++
 1 files changed

// File: rtl/departure_interlock.sv
// Departure-direction airlock sequencer: cabin -> inner door -> depressurize -> outer door.
// Moore FSM with a shared pump countdown and a registered completion pulse.
module departure_interlock #(
    parameter int PUMP_CYCLES    = 8,
    parameter int REPRESS_CYCLES = 8,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             depart_req,
    input  logic             inner_cmd,
    input  logic             outer_cmd,
    input  logic             abort,
    output logic             inner_open,
    output logic             outer_open,
    output logic             pressurized,
    output logic             pump_active,
    output logic [CNT_W-1:0] countdown,
    output logic             wait_var,
    output logic             finished_var
);

    typedef enum logic [2:0] {
        IDLE,
        INNER_OPEN,
        DEPRESS,
        VACUUM,
        OUTER_OPEN,
        REPRESS
    } state_t;

    localparam logic [CNT_W-1:0] PUMP_LOAD    = CNT_W'(PUMP_CYCLES);
    localparam logic [CNT_W-1:0] REPRESS_LOAD = CNT_W'(REPRESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             finished, finished_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            finished <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            finished <= finished_next;
        end
    end

    // count_next defaults to zero so the countdown reads 0 outside the pump states.
    always_comb begin
        state_next    = state;
        count_next    = '0;
        finished_next = 1'b0;
        case (state)
            IDLE: begin
                if (depart_req && inner_cmd) state_next = INNER_OPEN;
            end
            INNER_OPEN: begin
                if (!inner_cmd) begin
                    state_next = DEPRESS;
                    count_next = PUMP_LOAD;
                end
            end
            DEPRESS: begin
                // abort takes priority over the pump finishing in the same cycle
                if (abort) begin
                    state_next = REPRESS;
                    count_next = REPRESS_LOAD;
                end else if (count == CNT_ONE) begin
                    state_next = VACUUM;
                end else begin
                    count_next = count - CNT_ONE;
                end
            end
            VACUUM: begin
                if (outer_cmd) state_next = OUTER_OPEN;
            end
            OUTER_OPEN: begin
                if (!outer_cmd) begin
                    state_next = REPRESS;
                    count_next = REPRESS_LOAD;
                end
            end
            REPRESS: begin
                if (count == CNT_ONE) begin
                    state_next    = IDLE;
                    finished_next = 1'b1;
                end else begin
                    count_next = count - CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        inner_open  = 1'b0;
        outer_open  = 1'b0;
        pressurized = 1'b0;
        pump_active = 1'b0;
        case (state)
            IDLE:       pressurized = 1'b1;
            INNER_OPEN: begin
                inner_open  = 1'b1;
                pressurized = 1'b1;
            end
            DEPRESS:    pump_active = 1'b1;
            VACUUM:     pressurized = 1'b0;
            OUTER_OPEN: outer_open  = 1'b1;
            REPRESS:    pump_active = 1'b1;
            default:    pressurized = 1'b1;
        endcase
    end

    assign countdown    = count;
    assign wait_var     = pump_active;
    assign finished_var = finished;

endmodule
